branch_resolve_x: RTL

//  X-stage branch resolution for the TinyRV1 pipeline. Holds the D->X pipeline

---
 rtl/tinyrv1_pkg.sv | 16 +
 rtl/EqComparator_32b_RTL.sv | 10 +
 rtl/branch_resolve_x.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/tinyrv1_pkg.sv
// Shared TinyRV1 pipeline types: branch kinds and X-stage squash FSM states.
package tinyrv1_pkg;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_BEQ  = 2'b01,
        BR_BNE  = 2'b10,
        BR_JAL  = 2'b11
    } br_type_t;

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } squash_state_t;

endpackage

// File: rtl/EqComparator_32b_RTL.sv
// 32-bit equality comparator fed from the X-stage operand register.
module EqComparator_32b_RTL (
    input  logic [31:0] in0,
    input  logic [31:0] in1,
    output logic        eq
);

    assign eq = (in0 == in1);

endmodule

// File: rtl/branch_resolve_x.sv
// X-stage branch resolution: D->X register, beq/bne/jal resolve, registered
// redirect, wrong-path squash FSM and saturating taken-branch counter.
module branch_resolve_x
    import tinyrv1_pkg::*;
#(
    parameter int unsigned SQUASH_CYCLES = 2,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d_val,
    output logic             d_rdy,
    input  logic [1:0]       d_br_type,
    input  logic [31:0]      d_op0,
    input  logic [31:0]      d_op1,
    input  logic [31:0]      d_pc,
    input  logic [31:0]      d_imm,
    output logic [31:0]      cmp_in0,
    output logic [31:0]      cmp_in1,
    input  logic             cmp_eq,
    output logic             x_val,
    input  logic             x_rdy,
    output logic [31:0]      x_pc,
    output logic             redirect_val,
    output logic [31:0]      redirect_pc,
    output logic             squash,
    output logic [CNT_W-1:0] taken_count
);

    localparam int unsigned SQ_W = (SQUASH_CYCLES > 1) ? $clog2(SQUASH_CYCLES) : 1;

    logic              r_x_val;
    br_type_t          r_x_type;
    logic [31:0]       r_x_op0;
    logic [31:0]       r_x_op1;
    logic [31:0]       r_x_pc;
    logic [31:0]       r_x_imm;

    squash_state_t     r_state;
    squash_state_t     w_state_nxt;
    logic [SQ_W-1:0]   r_sq_cnt;
    logic [SQ_W-1:0]   w_sq_cnt_nxt;

    logic              r_redir_val;
    logic [31:0]       r_redir_pc;
    logic [CNT_W-1:0]  r_taken_cnt;

    logic              w_x_fire;
    logic              w_taken;
    logic              w_load;
    logic [31:0]       w_target;
    logic              w_unused_eq;

    // Internal comparator mirrors the exported cmp_* path; resolution uses cmp_eq.
    EqComparator_32b_RTL u_eq (
        .in0 (r_x_op0),
        .in1 (r_x_op1),
        .eq  (w_unused_eq)
    );

    assign d_rdy    = !r_x_val || x_rdy;
    assign w_x_fire = r_x_val && x_rdy;
    assign w_target = r_x_pc + r_x_imm;
    assign w_load   = d_val && (r_state == RUN) && !w_taken;

    always_comb begin
        w_taken = 1'b0;
        if (w_x_fire) begin
            case (r_x_type)
                BR_BEQ:  w_taken = cmp_eq;
                BR_BNE:  w_taken = !cmp_eq;
                BR_JAL:  w_taken = 1'b1;
                default: w_taken = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_x_val <= 1'b0;
        end else if (d_rdy) begin
            r_x_val <= w_load;
        end
    end

    // Data fields are don't-care while r_x_val is low, so they carry no reset.
    always_ff @(posedge clk) begin
        if (d_rdy && w_load) begin
            r_x_type <= br_type_t'(d_br_type);
            r_x_op0  <= d_op0;
            r_x_op1  <= d_op1;
            r_x_pc   <= d_pc;
            r_x_imm  <= d_imm;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_sq_cnt_nxt = r_sq_cnt;
        case (r_state)
            RUN: begin
                if (w_taken && (SQUASH_CYCLES > 1)) begin
                    w_state_nxt  = SQUASH;
                    w_sq_cnt_nxt = SQ_W'(SQUASH_CYCLES - 1);
                end
            end
            SQUASH: begin
                if (r_sq_cnt == SQ_W'(1)) begin
                    w_state_nxt  = RUN;
                    w_sq_cnt_nxt = '0;
                end else begin
                    w_sq_cnt_nxt = r_sq_cnt - SQ_W'(1);
                end
            end
            default: begin
                w_state_nxt  = RUN;
                w_sq_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= RUN;
            r_sq_cnt    <= '0;
            r_redir_val <= 1'b0;
            r_redir_pc  <= '0;
            r_taken_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_sq_cnt    <= w_sq_cnt_nxt;
            r_redir_val <= w_taken;
            if (w_taken) begin
                r_redir_pc <= w_target;
                if (r_taken_cnt != '1) begin
                    r_taken_cnt <= r_taken_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign cmp_in0      = r_x_op0;
    assign cmp_in1      = r_x_op1;
    assign x_val        = r_x_val;
    assign x_pc         = r_x_pc;
    assign redirect_val = r_redir_val;
    assign redirect_pc  = r_redir_pc;
    assign squash       = (r_state == SQUASH) || r_redir_val;
    assign taken_count  = r_taken_cnt;

endmodule
